// File: rtl/aes_key_schedule_ctrl.sv
`timescale 1ns/1ps
// aes_key_schedule_ctrl: sequential AES-128 key expansion, one word per
// handshake, sharing an external SubWord unit. Optional: AES_KS_LASTKEY_EN.
module aes_key_schedule_ctrl (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [127:0] i_key,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_sub_req,
   output logic [31:0]  o_sub_word,
   input  logic         i_sub_ack,
   input  logic [31:0]  i_sub_word,
   output logic         o_w_valid,
   output logic [5:0]   o_w_idx,
   output logic [31:0]  o_w,
`ifdef AES_KS_LASTKEY_EN
   output logic [127:0] o_last_key,
`endif
   input  logic         i_w_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SUB,
      S_GEN,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [31:0] r_win [0:3];
   logic [7:0]  r_rcon;
   logic        r_busy;
   logic        r_done;
   logic        r_sub_req;
   logic [31:0] r_sub_word;
   logic        r_w_valid;
   logic [5:0]  r_w_idx;
   logic [31:0] r_w;

   logic        w_hs;
   logic        w_ack;
   logic [31:0] w_xor_a;
   logic [31:0] w_xor_b;
   logic [31:0] w_next;
   logic [31:0] w_rot;
   logic [31:0] w_init_nxt;
   logic [7:0]  w_rcon_nxt;
   logic [1:0]  w_init_sel;

   assign w_hs  = r_w_valid & i_w_ready;
   assign w_ack = r_sub_req & i_sub_ack;
   assign w_rot = {r_w[23:0], r_w[31:24]};
   assign w_init_sel = r_w_idx[1:0] + 2'd1;
   assign w_init_nxt = r_win[w_init_sel];
   assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

   // Operand select for the single shared word XOR: w[i-4] ^ t
   always_comb begin
      w_xor_a = r_win[1];
      w_xor_b = r_w;
      if (r_state == S_SUB) begin
         w_xor_a = r_win[0];
         w_xor_b = i_sub_word ^ {r_rcon, 24'h0};
      end
      w_next = w_xor_a ^ w_xor_b;
   end

   // Expansion FSM with registered outputs and sliding window
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_win[0]   <= '0;
         r_win[1]   <= '0;
         r_win[2]   <= '0;
         r_win[3]   <= '0;
         r_rcon     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sub_req  <= 1'b0;
         r_sub_word <= '0;
         r_w_valid  <= 1'b0;
         r_w_idx    <= '0;
         r_w        <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_win[0]  <= i_key[127:96];
                  r_win[1]  <= i_key[95:64];
                  r_win[2]  <= i_key[63:32];
                  r_win[3]  <= i_key[31:0];
                  r_rcon    <= 8'h01;
                  r_w_idx   <= '0;
                  r_w       <= i_key[127:96];
                  r_w_valid <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_INIT;
               end
            end
            S_INIT: begin
               if (w_hs) begin
                  r_w_idx <= r_w_idx + 6'd1;
                  if (r_w_idx == 6'd3) begin
                     r_w_valid  <= 1'b0;
                     r_sub_req  <= 1'b1;
                     r_sub_word <= w_rot;
                     r_state    <= S_SUB;
                  end else begin
                     r_w <= w_init_nxt;
                  end
               end
            end
            S_SUB: begin
               if (w_ack) begin
                  r_sub_req <= 1'b0;
                  r_w       <= w_next;
                  r_w_valid <= 1'b1;
                  r_rcon    <= w_rcon_nxt;
                  r_state   <= S_GEN;
               end
            end
            S_GEN: begin
               if (w_hs) begin
                  r_win[0] <= r_win[1];
                  r_win[1] <= r_win[2];
                  r_win[2] <= r_win[3];
                  r_win[3] <= r_w;
                  if (r_w_idx == 6'd43) begin
                     r_w_valid <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end else if (r_w_idx[1:0] == 2'd3) begin
                     r_w_valid  <= 1'b0;
                     r_sub_req  <= 1'b1;
                     r_sub_word <= w_rot;
                     r_w_idx    <= r_w_idx + 6'd1;
                     r_state    <= S_SUB;
                  end else begin
                     r_w     <= w_next;
                     r_w_idx <= r_w_idx + 6'd1;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef AES_KS_LASTKEY_EN
   logic [127:0] r_last_key;

   // Capture w40..w43 as they hand off, for decryption start key
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_key <= '0;
      end else if (r_state == S_GEN && w_hs && r_w_idx >= 6'd40) begin
         unique case (r_w_idx[1:0])
            2'd0: r_last_key[127:96] <= r_w;
            2'd1: r_last_key[95:64]  <= r_w;
            2'd2: r_last_key[63:32]  <= r_w;
            2'd3: r_last_key[31:0]   <= r_w;
            default: r_last_key <= r_last_key;
         endcase
      end
   end

   assign o_last_key = r_last_key;
`endif

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_sub_req  = r_sub_req;
   assign o_sub_word = r_sub_word;
   assign o_w_valid  = r_w_valid;
   assign o_w_idx    = r_w_idx;
   assign o_w        = r_w;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
`timescale 1ns/1ps
// tb_aes_key_schedule_ctrl: random-stall bench against a golden
// key-expansion model built from a computed S-box.
module tb_aes_key_schedule_ctrl;

   logic         clk;
   logic         i_rst_n;
   logic         i_start;
   logic [127:0] i_key;
   logic         o_busy;
   logic         o_done;
   logic         o_sub_req;
   logic [31:0]  o_sub_word;
   logic         i_sub_ack;
   logic [31:0]  i_sub_word;
   logic         o_w_valid;
   logic [5:0]   o_w_idx;
   logic [31:0]  o_w;
   logic         i_w_ready;
`ifdef AES_KS_LASTKEY_EN
   logic [127:0] o_last_key;
`endif

   aes_key_schedule_ctrl dut (
      .i_clk      (clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_key      (i_key),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_sub_req  (o_sub_req),
      .o_sub_word (o_sub_word),
      .i_sub_ack  (i_sub_ack),
      .i_sub_word (i_sub_word),
      .o_w_valid  (o_w_valid),
      .o_w_idx    (o_w_idx),
      .o_w        (o_w),
`ifdef AES_KS_LASTKEY_EN
      .o_last_key (o_last_key),
`endif
      .i_w_ready  (i_w_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0]  sbox [0:255];
   logic [31:0] exp_w [0:43];
   logic [31:0] got_w [0:43];
   logic [7:0]  rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [31:0] first_sub;
   bit          first_sub_seen;
   int          lat_max = 0;
   bit          spur = 0;
   int          lat_cur = 0;
   int          wcnt = 0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   function automatic logic [31:0] rot_w(input logic [31:0] v);
      return {v[23:0], v[31:24]};
   endfunction

   function automatic logic [31:0] sub_w(input logic [31:0] v);
      return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                   ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic gen_model(input logic [127:0] key);
      logic [7:0]  rc;
      logic [31:0] t;
      exp_w[0] = key[127:96];
      exp_w[1] = key[95:64];
      exp_w[2] = key[63:32];
      exp_w[3] = key[31:0];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = exp_w[i-1];
         if (i % 4 == 0) begin
            t = sub_w(rot_w(t)) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         exp_w[i] = exp_w[i-4] ^ t;
      end
   endtask

   // SubWord responder with random latency and optional spurious acks
   always @(negedge clk) begin
      if (o_sub_req) begin
         if (wcnt >= lat_cur) begin
            i_sub_ack  = 1'b1;
            i_sub_word = sub_w(o_sub_word);
            wcnt = 0;
            lat_cur = $urandom_range(0, lat_max);
         end else begin
            i_sub_ack = 1'b0;
            wcnt++;
         end
      end else begin
         wcnt = 0;
         i_sub_ack  = spur && ($urandom_range(0, 3) == 0);
         i_sub_word = $urandom;
      end
   end

   task automatic run_exp(input logic [127:0] key, input bit rnd,
                          input int abort_at);
      int          nxt;
      int          cyc;
      bit          done_seen;
      bit          held_v;
      bit          held_s;
      logic [31:0] held_w;
      logic [5:0]  held_i;
      logic [31:0] held_sw;
      logic [31:0] rcw;
      gen_model(key);
      nxt = 0;
      cyc = 0;
      done_seen = 0;
      held_v = 0;
      held_s = 0;
      first_sub_seen = 0;
      @(negedge clk);
      i_key = key;
      i_start = 1'b1;
      i_w_ready = 1'b0;
      while (!done_seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         i_start = rnd && ($urandom_range(0, 7) == 0);
         i_key = rnd ? {$urandom, $urandom, $urandom, $urandom} : key;
         i_w_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (abort_at >= 0 && o_w_valid && o_w_idx == 6'(abort_at)) begin
            i_w_ready = 1'b0;
            i_start = 1'b0;
            #2;
            i_rst_n = 1'b0;
            #1;
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_sub_req", o_sub_req, 0);
            chk("rst_sub_word", o_sub_word, 0);
            chk("rst_w_valid", o_w_valid, 0);
            chk("rst_w_idx", o_w_idx, 0);
            chk("rst_w", o_w, 0);
`ifdef AES_KS_LASTKEY_EN
            chk("rst_last_key", o_last_key, 0);
`endif
            repeat (3) begin
               @(negedge clk);
               #2;
               chk("rst_no_done", o_done, 0);
            end
            i_rst_n = 1'b1;
            return;
         end
         #2;
         if (o_done) begin
            i_start = 1'b0;
            chk("done_count", nxt, 44);
            chk("done_busy", o_busy, 0);
            if (!rnd) chk("done_cycle", cyc, 55);
`ifdef AES_KS_LASTKEY_EN
            chk("last_key", o_last_key,
                {exp_w[40], exp_w[41], exp_w[42], exp_w[43]});
`endif
            done_seen = 1;
         end else begin
            chk("busy", o_busy, 1);
         end
         if (held_v) begin
            chk("w_hold", o_w, held_w);
            chk("idx_hold", o_w_idx, held_i);
         end
         held_v = 0;
         if (o_w_valid) begin
            if (i_w_ready) begin
               chk("w_val", o_w, (nxt < 44) ? exp_w[nxt] : 32'hx);
               chk("w_idx", o_w_idx, nxt);
               if (nxt < 44) got_w[nxt] = o_w;
               if (nxt >= 4 && nxt < 44 && nxt % 4 == 0) begin
                  rcw = o_w ^ got_w[nxt-4] ^ sub_w(rot_w(got_w[nxt-1]));
                  chk("rcon", rcw, {rcon_tab[nxt/4-1], 24'h0});
               end
               nxt++;
            end else begin
               held_v = 1;
               held_w = o_w;
               held_i = o_w_idx;
            end
         end
         if (o_sub_req) begin
            if (held_s) chk("sub_hold", o_sub_word, held_sw);
            else chk("sub_word", o_sub_word,
                     (nxt >= 4) ? rot_w(exp_w[nxt-1]) : 32'hx);
            if (!first_sub_seen) begin
               first_sub = o_sub_word;
               first_sub_seen = 1;
            end
            held_s = !i_sub_ack;
            held_sw = o_sub_word;
         end else begin
            held_s = 0;
         end
      end
      i_start = 1'b0;
      chk("done_seen", done_seen, 1);
   endtask

   localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_key = '0;
      i_w_ready = 1'b0;
      i_sub_ack = 1'b0;
      i_sub_word = '0;
      build_sbox();
      repeat (2) @(negedge clk);
      #2;
      chk("reset_busy", o_busy, 0);
      chk("reset_done", o_done, 0);
      chk("reset_sub_req", o_sub_req, 0);
      chk("reset_sub_word", o_sub_word, 0);
      chk("reset_w_valid", o_w_valid, 0);
      chk("reset_w_idx", o_w_idx, 0);
      chk("reset_w", o_w, 0);
      @(negedge clk);
      i_rst_n = 1'b1;

      lat_max = 0;
      spur = 0;
      run_exp(FIPS, 0, -1);
      chk("fips_first_sub", first_sub, 32'hcf4f3c09);
      chk("fips_w4", got_w[4], 32'ha0fafe17);
      chk("fips_w43", got_w[43], 32'hb6630ca6);
`ifdef AES_KS_LASTKEY_EN
      chk("fips_last_key", o_last_key,
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

      lat_max = 5;
      spur = 1;
      run_exp(FIPS, 1, -1);
      run_exp({$urandom, $urandom, $urandom, $urandom}, 1, -1);

      run_exp(FIPS, 1, 21);
      run_exp(128'h0, 1, -1);
      chk("zero_w4", got_w[4], 32'h62636363);
      chk("zero_w43", got_w[43], exp_w[43]);

      repeat (3) @(negedge clk);
      #2;
      chk("idle_busy", o_busy, 0);
      chk("idle_valid", o_w_valid, 0);
      chk("idle_sub_req", o_sub_req, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
